// File: rtl/dbus_uncached_axi_bridge.sv
// Uncached data-bus responder: turns one held CPU read/write request into one
// single-beat AXI4 transaction and keeps the CPU stalled until the DONE cycle.
module dbus_uncached_axi_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID = ID_WIDTH'(2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dbus_read,
    input  logic                  dbus_write,
    input  logic [ADDR_WIDTH-1:0] dbus_address,
    input  logic [3:0]            dbus_byteenable,
    input  logic [DATA_WIDTH-1:0] dbus_wrdata,
    output logic                  dbus_stall,
    output logic [DATA_WIDTH-1:0] dbus_rddata,
    output logic                  bus_error,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_WIDTH-1:0]   awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rddata_q, rddata_d;
    logic                  err_q, err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;

    logic [1:0]            off;
    logic [2:0]            size;

    // Lowest enabled lane gives the byte offset; irregular patterns fall back to a full word.
    always_comb begin
        off  = 2'd0;
        size = 3'd2;
        case (be_q)
            4'b1111: begin size = 3'd2; off = 2'd0; end
            4'b0011: begin size = 3'd1; off = 2'd0; end
            4'b1100: begin size = 3'd1; off = 2'd2; end
            4'b0001: begin size = 3'd0; off = 2'd0; end
            4'b0010: begin size = 3'd0; off = 2'd1; end
            4'b0100: begin size = 3'd0; off = 2'd2; end
            4'b1000: begin size = 3'd0; off = 2'd3; end
            default: begin size = 3'd2; off = 2'd0; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rddata_d  = rddata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        bus_error = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dbus_write || dbus_read) begin
                    addr_d  = dbus_address;
                    be_d    = dbus_byteenable;
                    wdata_d = dbus_wrdata;
                    state_d = dbus_write ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    rddata_d = rdata;
                    err_d    = (rresp != 2'b00);
                    state_d  = S_DONE;
                end
            end
            S_WR_REQ: begin
                // AW and W complete independently; either order or together.
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus_error = err_q;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rddata_q  <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rddata_q  <= rddata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign dbus_stall  = (dbus_read | dbus_write) & (state_q != S_DONE);
    assign dbus_rddata = rddata_q;

    assign arid    = AXI_ID;
    assign araddr  = {addr_q[ADDR_WIDTH-1:2], off};
    assign arlen   = 8'd0;
    assign arsize  = size;
    assign arburst = 2'b01;
    assign awid    = AXI_ID;
    assign awaddr  = {addr_q[ADDR_WIDTH-1:2], off};
    assign awlen   = 8'd0;
    assign awsize  = size;
    assign awburst = 2'b01;
    assign wdata   = wdata_q;
    assign wstrb   = be_q;
    assign wlast   = 1'b1;

    // Only one transaction is ever outstanding, so response IDs carry no information.
    logic unused_ok;
    assign unused_ok = ^{rid, rlast, bid, addr_q[1:0]};

endmodule
